// File: rtl/sprite_plotter.sv
// sprite_plotter: latches one object's position/alive, raster-plots its rectangle, then pulses done.
// Ports: clk, resetn, enable, draw_sel, pos_x, pos_y, alive in; x_out, y_out, colour, plot, done out.
module sprite_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SHIP_W = 8,
  parameter int SHIP_H = 8,
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 4,
  parameter logic [2:0] PLAYER_COLOUR = 3'b010,
  parameter logic [2:0] ENEMY_COLOUR = 3'b100,
  parameter logic [2:0] BULLET_COLOUR = 3'b111
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [3:0]  draw_sel,
  input  logic [47:0] pos_x,
  input  logic [41:0] pos_y,
  input  logic [5:0]  alive,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLOT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  bx_q, bx_d;
  logic [6:0]  by_q, by_d;
  logic [3:0]  w_q, w_d;
  logic [3:0]  h_q, h_d;
  logic [2:0]  col_q, col_d;
  logic [3:0]  cx_q, cx_d;
  logic [3:0]  cy_q, cy_d;

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic        sel_alive;
  logic [3:0]  sel_w;
  logic [3:0]  sel_h;
  logic [2:0]  sel_col;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic        in_bounds;
  logic        is_plot;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_alive = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (draw_sel == 4'(k)) begin
        sel_x = pos_x[8*k +: 8];
        sel_y = pos_y[7*k +: 7];
        sel_alive = alive[k];
      end
    end
  end

  always_comb begin
    sel_w = 4'(SHIP_W);
    sel_h = 4'(SHIP_H);
    sel_col = ENEMY_COLOUR;
    unique case (1'b1)
      (draw_sel == 4'd0): sel_col = PLAYER_COLOUR;
      (draw_sel == 4'd5): begin
        sel_w = 4'(BULLET_W);
        sel_h = 4'(BULLET_H);
        sel_col = BULLET_COLOUR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bx_d = bx_q;
    by_d = by_q;
    w_d = w_q;
    h_d = h_q;
    col_d = col_q;
    cx_d = cx_q;
    cy_d = cy_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        bx_d = sel_x;
        by_d = sel_y;
        w_d = sel_w;
        h_d = sel_h;
        col_d = sel_alive ? sel_col : 3'b000;
        cx_d = '0;
        cy_d = '0;
        state_d = (draw_sel > 4'd5) ? DONE : PLOT;
      end
      PLOT: begin
        if (cx_q == w_q - 4'd1) begin
          cx_d = '0;
          if (cy_q == h_q - 4'd1) begin
            state_d = DONE;
          end else begin
            cy_d = cy_q + 4'd1;
          end
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      DONE: begin
        state_d = enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bx_q <= '0;
      by_q <= '0;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      state_q <= state_d;
      bx_q <= bx_d;
      by_q <= by_d;
      w_q <= w_d;
      h_q <= h_d;
      col_q <= col_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  // Outputs decode registered state only; off-screen pixels still consume a cycle.
  assign sum_x = {1'b0, bx_q} + {5'b0, cx_q};
  assign sum_y = {1'b0, by_q} + {4'b0, cy_q};
  assign in_bounds = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
  assign is_plot = (state_q == PLOT);

  assign plot = is_plot && in_bounds;
  assign x_out = is_plot ? sum_x[7:0] : '0;
  assign y_out = is_plot ? sum_y[6:0] : '0;
  assign colour = is_plot ? col_q : '0;
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: scoreboard bench for sprite_plotter.
// Expected pixels are queued at launch and popped on each plot strobe.
module tb_sprite_plotter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  draw_sel = '0;
  logic [47:0] pos_x = '0;
  logic [41:0] pos_y = '0;
  logic [5:0]  alive = '0;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];

  sprite_plotter dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .draw_sel(draw_sel),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .alive(alive),
    .x_out(x_out),
    .y_out(y_out),
    .colour(colour),
    .plot(plot),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && plot) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required none",
                 x_out, y_out, colour);
      end else begin
        pix_t e;
        e = sb.pop_front();
        if ({x_out, y_out, colour} !== e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   x_out, y_out, colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic push_obj(input int sel, input logic [7:0] px,
                          input logic [6:0] py, input logic alv);
    int w, h, sx, sy;
    logic [2:0] col;
    pix_t p;
    if (sel > 5) return;
    w = (sel == 5) ? 2 : 8;
    h = (sel == 5) ? 4 : 8;
    if (!alv) col = 3'b000;
    else if (sel == 0) col = 3'b010;
    else if (sel == 5) col = 3'b111;
    else col = 3'b100;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        sx = int'(px) + cx;
        sy = int'(py) + cy;
        if (sx < 160 && sy < 120) begin
          p.x = 8'(sx);
          p.y = 7'(sy);
          p.c = col;
          sb.push_back(p);
        end
      end
    end
  endtask

  task automatic scramble();
    pos_x = {16'($urandom), $urandom};
    pos_y = {10'($urandom), $urandom};
    alive = 6'($urandom);
  endtask

  // Call from IDLE; returns during the LOAD cycle.
  task automatic launch(input int sel, input logic [7:0] px,
                        input logic [6:0] py, input logic alv);
    scramble();
    if (sel <= 5) begin
      pos_x[8*sel +: 8] = px;
      pos_y[7*sel +: 7] = py;
      alive[sel] = alv;
    end
    draw_sel = 4'(sel);
    push_obj(sel, px, py, alv);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  // Cycle 0 is the LOAD cycle; inputs are scrambled once LOAD has sampled.
  task automatic measure(input int maxc, output int np, output int first,
                         output int last, output int dat, output int nd);
    np = 0; first = -1; last = -1; dat = -1; nd = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (plot) begin
        np++;
        if (first < 0) first = i;
        last = i;
      end
      if (done) begin
        nd++;
        dat = i;
      end
      if (i == 1) begin
        scramble();
        draw_sel = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    int nd, np;
    #22;
    checks++;
    if ({plot, done, x_out, y_out, colour} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {plot, done, x_out, y_out, colour});
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    nd = 0; np = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (plot) np++;
    end
    checks++;
    if (nd + np !== 0) begin
      errors++;
      $display("FAIL reset_idle: got done=%0d plot=%0d, required 0 0", nd, np);
    end
  endtask

  task automatic test_player();
    int np, f, l, d, nd;
    launch(0, 8'd10, 7'd20, 1'b1);
    measure(80, np, f, l, d, nd);
    checks++;
    if (np !== 64 || f !== 1 || l !== 64) begin
      errors++;
      $display("FAIL player_plot: got n=%0d first=%0d last=%0d, required 64 1 64",
               np, f, l);
    end
    checks++;
    if (nd !== 1 || d !== 65) begin
      errors++;
      $display("FAIL player_done: got n=%0d at=%0d, required 1 65", nd, d);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL player_left: got %0d, required 0", sb.size());
    end
  endtask

  task automatic test_dead_enemy();
    int np, f, l, d, nd;
    launch(2, 8'd40, 7'd30, 1'b0);
    measure(80, np, f, l, d, nd);
    checks++;
    if (np !== 64 || d !== 65 || nd !== 1) begin
      errors++;
      $display("FAIL dead_enemy: got n=%0d done_at=%0d nd=%0d, required 64 65 1",
               np, d, nd);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL dead_left: got %0d, required 0", sb.size());
    end
  endtask

  task automatic test_clipped_bullet();
    int np, f, l, d, nd;
    launch(5, 8'd159, 7'd118, 1'b1);
    measure(20, np, f, l, d, nd);
    checks++;
    if (np !== 2 || f !== 1 || l !== 3) begin
      errors++;
      $display("FAIL clip_plot: got n=%0d first=%0d last=%0d, required 2 1 3",
               np, f, l);
    end
    checks++;
    if (nd !== 1 || d !== 9) begin
      errors++;
      $display("FAIL clip_done: got n=%0d at=%0d, required 1 9", nd, d);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL clip_left: got %0d, required 0", sb.size());
    end
  endtask

  task automatic test_invalid();
    int np, f, l, d, nd;
    launch(7, 8'd0, 7'd0, 1'b1);
    measure(10, np, f, l, d, nd);
    checks++;
    if (np !== 0 || nd !== 1 || d !== 1) begin
      errors++;
      $display("FAIL invalid_sel: got n=%0d nd=%0d at=%0d, required 0 1 1",
               np, nd, d);
    end
  endtask

  task automatic test_reset_midplot();
    int nd, np;
    launch(0, 8'd50, 7'd60, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({plot, done, x_out, y_out, colour} !== 20'd0) begin
      errors++;
      $display("FAIL midplot_reset: got %h, required 0",
               {plot, done, x_out, y_out, colour});
    end
    sb.delete();
    enable = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    nd = 0; np = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (plot) np++;
    end
    checks++;
    if (nd + np !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: got done=%0d plot=%0d, required 0 0", nd, np);
    end
  endtask

  task automatic test_closed_loop();
    logic [7:0] cpx[6];
    logic [6:0] cpy[6];
    logic [5:0] alv;
    int dt[11];
    int dcnt, cur, nxt, late_plot, gap, expg;
    logic saw;
    alv = 6'b101101;
    for (int k = 0; k < 6; k++) begin
      cpx[k] = 8'(10 + 20 * k);
      cpy[k] = 7'(5 + 15 * k);
      pos_x[8*k +: 8] = cpx[k];
      pos_y[7*k +: 7] = cpy[k];
    end
    alive = alv;
    @(posedge clk);
    #1;
    cur = 0;
    draw_sel = 4'd0;
    push_obj(0, cpx[0], cpy[0], alv[0]);
    enable = 1'b1;
    dcnt = 0;
    late_plot = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      saw = 1'b0;
      if (plot && dcnt >= 10) late_plot++;
      if (done) begin
        dcnt++;
        if (dcnt <= 10) dt[dcnt] = i;
        saw = 1'b1;
      end
      if (dcnt == 9 && enable && i == dt[9] + 30) enable = 1'b0;
      if (dcnt >= 10 && i >= dt[10] + 100) break;
      @(posedge clk);
      #1;
      if (saw) begin
        nxt = (cur == 5) ? 0 : cur + 1;
        cur = nxt;
        draw_sel = 4'(nxt);
        if (enable) push_obj(nxt, cpx[nxt], cpy[nxt], alv[nxt]);
      end
    end
    checks++;
    if (dcnt !== 10) begin
      errors++;
      $display("FAIL loop_done_count: got %0d, required 10", dcnt);
    end else begin
      checks++;
      if (dt[1] !== 66) begin
        errors++;
        $display("FAIL loop_first_done: got %0d, required 66", dt[1]);
      end
      for (int k = 2; k <= 10; k++) begin
        gap = dt[k] - dt[k-1];
        expg = (((k - 1) % 6) == 5) ? 10 : 66;
        checks++;
        if (gap !== expg) begin
          errors++;
          $display("FAIL loop_gap_%0d: got %0d, required %0d", k, gap, expg);
        end
      end
      checks++;
      if (dt[7] - dt[1] !== 340) begin
        errors++;
        $display("FAIL rotation: got %0d, required 340", dt[7] - dt[1]);
      end
    end
    checks++;
    if (late_plot !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL loop_stop: got late=%0d left=%0d, required 0 0",
               late_plot, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_player();
    test_dead_enemy();
    test_clipped_bullet();
    test_invalid();
    test_reset_midplot();
    test_closed_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
